// File: rtl/byte_decode_d_pkg.sv
// Shared constants, FSM state type and the legal-width check for the ByteDecode_d unpacker.
package byte_decode_d_pkg;

    localparam int unsigned KyberN = 256;
    localparam int unsigned KyberQ = 3329;
    localparam int unsigned AccW   = 24;
    localparam int unsigned CntW   = 5;
    localparam int unsigned DMax   = 12;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    function automatic logic d_legal(input logic [3:0] d);
        return (d >= 4'd1) && (d <= 4'd12);
    endfunction

endpackage

// File: rtl/byte_decode_d_if.sv
// Byte-in / coefficient-out streaming bus with valid/ready on both sides.
interface byte_decode_d_if #(
    parameter int unsigned COEF_W = 16,
    parameter int unsigned IDX_W  = 8
);
    logic              din_valid;
    logic [7:0]        din;
    logic              din_ready;
    logic              dout_valid;
    logic [COEF_W-1:0] dout;
    logic [IDX_W-1:0]  dout_index;
    logic              dout_last;
    logic              dout_ready;

    modport slave (
        input  din_valid, din, dout_ready,
        output din_ready, dout_valid, dout, dout_index, dout_last
    );

    modport master (
        output din_valid, din, dout_ready,
        input  din_ready, dout_valid, dout, dout_index, dout_last
    );
endinterface

// File: rtl/byte_decode_d_accum.sv
// Bit accumulator: bytes are appended above the pending bits, coefficients leave from the bottom.
module byte_decode_d_accum
    import byte_decode_d_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            clear_i,
    input  logic            push_i,
    input  logic [7:0]      din_i,
    input  logic            pop_i,
    input  logic [3:0]      d_i,
    output logic [CntW-1:0] cnt_o,
    output logic [DMax-1:0] pop_data_o
);
    logic [AccW-1:0] acc_q, acc_d, acc_shift;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_shift;

    // Pop is applied first so a simultaneous push lands directly above the remaining bits.
    always_comb begin
        acc_shift = acc_q;
        cnt_shift = cnt_q;
        if (pop_i) begin
            acc_shift = acc_q >> d_i;
            cnt_shift = cnt_q - CntW'(d_i);
        end
        acc_d = acc_shift;
        cnt_d = cnt_shift;
        if (push_i) begin
            acc_d = acc_shift | (AccW'(din_i) << cnt_shift);
            cnt_d = cnt_shift + CntW'(8);
        end
        if (clear_i) begin
            acc_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign pop_data_o = acc_q[DMax-1:0] & ((DMax'(1) << d_i) - DMax'(1));

endmodule

// File: rtl/byte_decode_d.sv
// Streaming ByteDecode_d: unpacks one polynomial of N d-bit coefficients from a byte stream.
module byte_decode_d
    import byte_decode_d_pkg::*;
#(
    parameter int unsigned N      = KyberN,
    parameter int unsigned COEF_W = 16,
    parameter int unsigned Q      = KyberQ,
    parameter int unsigned IDX_W  = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [3:0]      d_sel_i,
    byte_decode_d_if.slave  bus,
    output logic            busy_o,
    output logic            done_o,
    output logic            cfg_err_o,
    output logic            range_err_o
);
    localparam int unsigned ByteW = $clog2(N * DMax / 8 + 1);

    state_e            state_q, state_d;
    logic [3:0]        d_q, d_d;
    logic [ByteW-1:0]  bytes_q, bytes_d, frame_bytes;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              dout_valid_q, dout_valid_d;
    logic [COEF_W-1:0] dout_q, dout_d;
    logic              done_q, done_d;
    logic              cfg_err_q, cfg_err_d;
    logic              range_err_q, range_err_d;

    logic            run, go, push, pop, out_hs, last_idx;
    logic [CntW-1:0] cnt;
    logic [DMax-1:0] pop_data;

    assign run         = (state_q == StRun);
    assign go          = !run && start_i && d_legal(d_sel_i);
    assign frame_bytes = ByteW'(N / 8) * ByteW'(d_q);
    assign last_idx    = (idx_q == IDX_W'(N - 1));

    // Ready is built from registered state only; the byte budget stops intake at frame end.
    assign bus.din_ready = run && (cnt <= CntW'(16)) && (bytes_q < frame_bytes);
    assign push          = bus.din_valid && bus.din_ready;
    assign pop           = run && (cnt >= CntW'(d_q)) && (!dout_valid_q || bus.dout_ready);
    assign out_hs        = dout_valid_q && bus.dout_ready;

    byte_decode_d_accum u_accum (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (go),
        .push_i    (push),
        .din_i     (bus.din),
        .pop_i     (pop),
        .d_i       (d_q),
        .cnt_o     (cnt),
        .pop_data_o(pop_data)
    );

    always_comb begin
        state_d      = state_q;
        d_d          = d_q;
        bytes_d      = bytes_q;
        idx_d        = idx_q;
        dout_valid_d = dout_valid_q;
        dout_d       = dout_q;
        done_d       = 1'b0;
        cfg_err_d    = 1'b0;
        range_err_d  = range_err_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (d_legal(d_sel_i)) begin
                        state_d     = StRun;
                        d_d         = d_sel_i;
                        bytes_d     = '0;
                        idx_d       = '0;
                        range_err_d = 1'b0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (push) bytes_d = bytes_q + ByteW'(1);
                if (out_hs) begin
                    idx_d        = idx_q + IDX_W'(1);
                    dout_valid_d = 1'b0;
                    if (last_idx) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
                if (pop) begin
                    dout_valid_d = 1'b1;
                    dout_d       = COEF_W'(pop_data);
                    if (d_q == 4'd12 && pop_data >= DMax'(Q)) range_err_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            d_q          <= '0;
            bytes_q      <= '0;
            idx_q        <= '0;
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            range_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            d_q          <= d_d;
            bytes_q      <= bytes_d;
            idx_q        <= idx_d;
            dout_valid_q <= dout_valid_d;
            dout_q       <= dout_d;
            done_q       <= done_d;
            cfg_err_q    <= cfg_err_d;
            range_err_q  <= range_err_d;
        end
    end

    assign bus.dout_valid = dout_valid_q;
    assign bus.dout       = dout_q;
    assign bus.dout_index = idx_q;
    assign bus.dout_last  = dout_valid_q && last_idx;
    assign busy_o         = run;
    assign done_o         = done_q;
    assign cfg_err_o      = cfg_err_q;
    assign range_err_o    = range_err_q;

endmodule

// File: tb/tb_byte_decode_d.sv
// Directed bench for byte_decode_d with a bit-serial reference model feeding a coefficient scoreboard.
module tb_byte_decode_d;
    import byte_decode_d_pkg::*;

    localparam int unsigned N      = 256;
    localparam int unsigned COEF_W = 16;
    localparam int unsigned IDX_W  = 8;
    localparam int unsigned QV     = 3329;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_i;
    logic [3:0] d_sel_i;
    logic       busy_o, done_o, cfg_err_o, range_err_o;

    byte_decode_d_if #(.COEF_W(COEF_W), .IDX_W(IDX_W)) bus ();

    byte_decode_d #(.N(N), .COEF_W(COEF_W), .Q(QV), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start_i),
        .d_sel_i    (d_sel_i),
        .bus        (bus),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .cfg_err_o  (cfg_err_o),
        .range_err_o(range_err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0]        frame [$];
    logic [COEF_W-1:0] exp_q [$];
    bit                exp_range;
    bit                drop_seen;
    int                last_cycles;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] d);
        start_i = 1'b1;
        d_sel_i = d;
        step();
        start_i = 1'b0;
    endtask

    // Reference: coefficient i is bits [i*d +: d] of the LSB-first bit stream.
    task automatic build_expect(input int d);
        logic [COEF_W-1:0] v;
        logic [7:0]        b;
        int                pos;
        exp_q.delete();
        exp_range = 1'b0;
        for (int i = 0; i < N; i++) begin
            v = '0;
            for (int k = 0; k < d; k++) begin
                pos  = i * d + k;
                b    = frame[pos / 8];
                v[k] = b[pos % 8];
            end
            if (d == 12 && v >= COEF_W'(QV)) exp_range = 1'b1;
            exp_q.push_back(v);
        end
    endtask

    task automatic run_frame(input int d, input bit bp, input int poke_cyc, input int abort_after,
                             output bit aborted);
        int                nbytes;
        int                sent;
        int                idx;
        int                cyc;
        bit                stalled;
        logic [COEF_W-1:0] prev_dout;
        nbytes    = N * d / 8;
        sent      = 0;
        idx       = 0;
        cyc       = 0;
        stalled   = 1'b0;
        prev_dout = '0;
        aborted   = 1'b0;
        drop_seen = 1'b0;
        build_expect(d);
        while (idx < N && cyc < 20000) begin
            bus.din_valid  = 1'b1;
            bus.din        = (sent < nbytes) ? frame[sent] : 8'hEE;
            bus.dout_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            start_i        = (cyc == poke_cyc);
            d_sel_i        = 4'd1;
            @(negedge clk);
            if (stalled) begin
                check("stall_valid", {31'b0, bus.dout_valid}, 32'd1);
                check("stall_dout", 32'(bus.dout), 32'(prev_dout));
            end
            if (!bus.din_ready && sent < nbytes && busy_o) drop_seen = 1'b1;
            if (bus.din_valid && bus.din_ready) sent++;
            if (bus.dout_valid && bus.dout_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_coef", 32'd1, 32'd0);
                end else begin
                    check("coef", 32'(bus.dout), 32'(exp_q.pop_front()));
                end
                check("index", 32'(bus.dout_index), 32'(idx));
                check("last", {31'b0, bus.dout_last}, 32'(idx == N - 1));
                idx++;
            end
            stalled   = bus.dout_valid && !bus.dout_ready;
            prev_dout = bus.dout;
            step();
            cyc++;
            if (abort_after > 0 && sent >= abort_after) begin
                aborted = 1'b1;
                break;
            end
        end
        start_i        = 1'b0;
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b0;
        last_cycles    = cyc;
        if (!aborted) begin
            check("frame_complete", 32'(idx), 32'(N));
            check("bytes_consumed", 32'(sent), 32'(nbytes));
            check("done_pulse", {31'b0, done_o}, 32'd1);
            check("busy_end", {31'b0, busy_o}, 32'd0);
            check("din_ready_end", {31'b0, bus.din_ready}, 32'd0);
            check("range_err", {31'b0, range_err_o}, {31'b0, exp_range});
            step();
            check("done_clear", {31'b0, done_o}, 32'd0);
        end
    endtask

    initial begin
        bit ab;
        reset          = 1'b1;
        start_i        = 1'b0;
        d_sel_i        = 4'd0;
        bus.din_valid  = 1'b0;
        bus.din        = 8'h00;
        bus.dout_ready = 1'b0;
        repeat (2) step();
        check("rst_din_ready", {31'b0, bus.din_ready}, 32'd0);
        check("rst_dout_valid", {31'b0, bus.dout_valid}, 32'd0);
        check("rst_dout", 32'(bus.dout), 32'd0);
        check("rst_dout_index", 32'(bus.dout_index), 32'd0);
        check("rst_dout_last", {31'b0, bus.dout_last}, 32'd0);
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_done", {31'b0, done_o}, 32'd0);
        check("rst_cfg_err", {31'b0, cfg_err_o}, 32'd0);
        check("rst_range_err", {31'b0, range_err_o}, 32'd0);
        reset = 1'b0;
        step();

        // d = 12, repeating 01 23 45 -> 0x301, 0x452, all below Q, one byte per cycle.
        frame.delete();
        for (int i = 0; i < 128; i++) begin
            frame.push_back(8'h01);
            frame.push_back(8'h23);
            frame.push_back(8'h45);
        end
        check("model_c0", 32'(frame[0]) | (32'(frame[1]) << 8), 32'h2301);
        do_start(4'd12);
        check("busy_start", {31'b0, busy_o}, 32'd1);
        run_frame(12, 1'b0, -1, 0, ab);
        check("d12_throughput", 32'(last_cycles <= 390), 32'd1);

        // d = 12 with an out-of-range first coefficient.
        frame[0] = 8'hFF;
        frame[1] = 8'hFF;
        frame[2] = 8'h0F;
        do_start(4'd12);
        run_frame(12, 1'b0, -1, 0, ab);

        // d = 1, leading 0xA5; next start also clears range_err.
        frame.delete();
        frame.push_back(8'hA5);
        for (int i = 1; i < 32; i++) frame.push_back(8'($urandom));
        do_start(4'd1);
        check("range_err_cleared", {31'b0, range_err_o}, 32'd0);
        run_frame(1, 1'b0, -1, 0, ab);
        check("d1_din_ready_drop", {31'b0, drop_seen}, 32'd1);

        // Illegal widths.
        do_start(4'd0);
        check("cfg_err_d0", {31'b0, cfg_err_o}, 32'd1);
        check("cfg_busy_d0", {31'b0, busy_o}, 32'd0);
        step();
        check("cfg_err_pulse", {31'b0, cfg_err_o}, 32'd0);
        do_start(4'd13);
        check("cfg_err_d13", {31'b0, cfg_err_o}, 32'd1);
        check("cfg_busy_d13", {31'b0, busy_o}, 32'd0);

        // d = 10 with random backpressure and a stray start mid-frame.
        frame.delete();
        for (int i = 0; i < 320; i++) frame.push_back(8'($urandom));
        do_start(4'd10);
        run_frame(10, 1'b1, 20, 0, ab);

        // Reset after 100 bytes of a d = 12 frame, then a clean d = 4 frame.
        frame.delete();
        for (int i = 0; i < 384; i++) frame.push_back(8'($urandom));
        do_start(4'd12);
        run_frame(12, 1'b1, -1, 100, ab);
        check("abort_reached", {31'b0, ab}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_din_ready", {31'b0, bus.din_ready}, 32'd0);
        check("mid_rst_dout_valid", {31'b0, bus.dout_valid}, 32'd0);
        check("mid_rst_dout", 32'(bus.dout), 32'd0);
        check("mid_rst_index", 32'(bus.dout_index), 32'd0);
        check("mid_rst_busy", {31'b0, busy_o}, 32'd0);
        check("mid_rst_range", {31'b0, range_err_o}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();
        frame.delete();
        for (int i = 0; i < 128; i++) frame.push_back(8'($urandom));
        do_start(4'd4);
        run_frame(4, 1'b0, -1, 0, ab);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/byte_decode_d.md
# byte_decode_d

Streaming Kyber ByteDecode_d unpacker: accepts a byte stream of one packed polynomial and emits N coefficients of d bits each (d = 1..12, selected per polynomial). It sits between the byte-level key/ciphertext input path and the coefficient datapath (NTT / decompress), replacing the fixed 12-bit decoder. It adds a runtime d selection, valid/ready backpressure on both sides, frame tracking with a last flag, and the FIPS 203 modulus check for d = 12.

## Interface
- N, 256, coefficients per polynomial; must be a multiple of 8
- COEF_W, 16, output coefficient width; must be ≥ 12
- Q, 3329, modulus for the d = 12 range check
- IDX_W, $clog2(N), coefficient index width
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle request to begin a polynomial; honoured only in IDLE
- d_sel  in  4  bits per coefficient, sampled with start
- din_valid  in  1  byte available
- din  in  8  packed byte, LSB-first bit order
- din_ready  out  1  byte accepted when din_valid & din_ready
- dout_valid  out  1  coefficient available
- dout  out  COEF_W  coefficient, zero-extended from d bits
- dout_index  out  IDX_W  coefficient position 0..N-1
- dout_last  out  1  high with coefficient N-1
- dout_ready  in  1  downstream accepts coefficient
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse after coefficient N-1 handshakes
- cfg_err  out  1  one-cycle pulse when start arrives with d_sel ∉ 1..12
- range_err  out  1  sticky: a d = 12 coefficient ≥ Q was emitted this frame

## Operation
- States: IDLE, RUN. IDLE→RUN on start with legal d_sel in IDLE: latch d, clear accumulator, byte counter, coefficient index and range_err. Illegal d_sel: stay IDLE, pulse cfg_err. start in RUN is ignored.
- RUN→IDLE on the handshake of coefficient N-1; done pulses the following cycle.
- Accumulator: 24-bit acc, count cnt 0..24. A push writes din at acc[cnt+7:cnt]. A pop takes acc[d-1:0] into the output register and shifts acc right by d. A push and a pop in the same cycle are combined: cnt' = cnt + 8 − d.
- din_ready = RUN & cnt ≤ 16 & bytes_in < N·d/8. Bytes beyond the frame are never accepted.
- pop = RUN & cnt ≥ d & (!dout_valid | dout_ready).
- dout_index increments on each output handshake. dout_last = dout_valid & dout_index == N-1.
- range_err sets when d = 12 and a popped value ≥ Q. The value is still emitted unmodified.
- At frame end cnt is 0, because N·d is a multiple of 8.
- Reset values: din_ready 0, dout_valid 0, dout 0, dout_index 0, dout_last 0, busy 0, done 0, cfg_err 0, range_err 0. State is IDLE, acc/cnt/counters 0.
- Reset mid-frame abandons the frame. A partially held coefficient is discarded.

## Timing
- Output is registered. dout_valid rises one clock after the edge where cnt first reaches ≥ d.
  - d ≤ 8: the edge after the first byte is accepted.
  - d = 12: the edge after the second byte is accepted.
- din_ready depends only on registered state (no ready→ready combinational path). dout_valid/dout are held stable while dout_ready is low.
- Throughput with dout_ready held high:
  - d ≥ 8: one byte per cycle sustained (d = 12: 3 bytes → 2 coefficients per 3 cycles).
  - d < 8: one coefficient per cycle, with din_ready throttled.
- busy rises the cycle after the accepted start. The first din_ready can also rise that cycle.

## Structure
- Shared kyber_pkg holds Q, N, the legal-d check function, and the ACC_W = 24 / CNT_W constants.
- Natural sub-module: kyber_bit_accum, holding acc/cnt, push/pop and the variable shift.
- Frame FSM, counters, range check and output register live in the top module.

## Test plan
- d = 12, bytes 0x01,0x23,0x45 → coefficients 0x301, 0x452. 384 bytes give exactly 256 coefficients, dout_last on index 255, done one cycle later. range_err stays 0.
- d = 12, bytes 0xFF,0xFF,0x0F → 0xFFF (4095 ≥ 3329) emitted unchanged and range_err sets. It clears on the next accepted start.
- d = 1, byte 0xA5 → coefficients 1,0,1,0,0,1,0,1. din_ready drops while bits are pending. The frame consumes 32 bytes.
- d = 10 with random dout_ready backpressure → coefficient sequence matches the reference model, no loss or duplication, and dout is stable while stalled.
- start with d_sel = 0 or 13 → cfg_err pulse and busy stays 0. start during RUN is ignored.
- Reset asserted after 100 bytes → all outputs 0 the same cycle. A new start with d = 4 decodes cleanly from index 0.
